// File: rtl/morse_keyer_seq.sv
// Morse keyer sequencer: keys one character or word space per valid/ready transfer,
// timing marks and gaps from NCO dot-unit ticks. Build macro FARNSWORTH_EN stretches gaps.
module morse_keyer_seq #(
  parameter int MAX_LEN    = 5,
  parameter int DASH_UNITS = 3,
  parameter int SYM_GAP    = 1,
  parameter int CHAR_GAP   = 3,
  parameter int WORD_EXTRA = 4,
  parameter int FW_MULT    = 3
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               tick,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_len,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic               in_space,
  output logic               nco_rst,
  output logic               key_out,
  output logic               busy,
  output logic               char_done
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

`ifdef FARNSWORTH_EN
  localparam int GAP_MULT = FW_MULT;
`else
  // FW_MULT is intentionally inert when Farnsworth spacing is not built in
  localparam int GAP_MULT = (FW_MULT != 0) ? 1 : 1;
`endif

  localparam int CHAR_UNITS = CHAR_GAP * GAP_MULT;
  localparam int WORD_UNITS = WORD_EXTRA * GAP_MULT;
  localparam int MAX_UNITS  = imax(imax(DASH_UNITS, SYM_GAP), imax(CHAR_UNITS, WORD_UNITS));
  localparam int CW         = imax(3, $clog2(MAX_UNITS + 1));

  localparam logic [CW-1:0] DOT_T   = CW'(1);
  localparam logic [CW-1:0] DASH_T  = CW'(DASH_UNITS);
  localparam logic [CW-1:0] SGAP_T  = CW'(SYM_GAP);
  localparam logic [CW-1:0] CGAP_T  = CW'(CHAR_UNITS);
  localparam logic [CW-1:0] WGAP_T  = CW'(WORD_UNITS);
  localparam logic [2:0]    LEN_MAX = 3'(MAX_LEN);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SYNC  = 3'd1;
  localparam logic [2:0] MARK  = 3'd2;
  localparam logic [2:0] SPACE = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      gap_tgt_reg;
  logic [2:0]         rem_reg;
  logic [MAX_LEN-1:0] code_reg;
  logic               space_reg;
  logic               key_reg;
  logic               ready_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               nco_reg;

  logic [CW-1:0] unit_tgt;
  logic [CW:0]   cnt_inc;
  logic          unit_hit;

  always_comb begin
    unit_tgt = gap_tgt_reg;
    case (state_reg)
      MARK:    unit_tgt = code_reg[MAX_LEN-1] ? DASH_T : DOT_T;
      SPACE:   unit_tgt = SGAP_T;
      default: unit_tgt = gap_tgt_reg;
    endcase
  end

  // The counter only advances below its target, so it can never wrap.
  assign cnt_inc  = {1'b0, cnt_reg} + (CW+1)'(1);
  assign unit_hit = tick && (cnt_inc >= {1'b0, unit_tgt});

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      gap_tgt_reg <= '0;
      rem_reg     <= '0;
      code_reg    <= '0;
      space_reg   <= 1'b0;
      key_reg     <= 1'b0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      nco_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      nco_reg  <= 1'b1;
      case (state_reg)
        IDLE: begin
          key_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
          cnt_reg   <= '0;
          if (in_valid && ready_reg) begin
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            nco_reg   <= 1'b0;
            rem_reg   <= (in_len > LEN_MAX) ? LEN_MAX : in_len;
            code_reg  <= in_code;
            space_reg <= in_space;
            state_reg <= SYNC;
          end
        end
        SYNC: begin
          cnt_reg <= '0;
          if (space_reg) begin
            gap_tgt_reg <= WGAP_T;
            state_reg   <= GAP;
          end else if (rem_reg == 3'd0) begin
            gap_tgt_reg <= CGAP_T;
            state_reg   <= GAP;
          end else begin
            key_reg   <= 1'b1;
            state_reg <= MARK;
          end
        end
        MARK: begin
          if (unit_hit) begin
            cnt_reg <= '0;
            key_reg <= 1'b0;
            if (rem_reg > 3'd1) begin
              rem_reg   <= rem_reg - 3'd1;
              code_reg  <= code_reg << 1;
              state_reg <= SPACE;
            end else begin
              gap_tgt_reg <= CGAP_T;
              state_reg   <= GAP;
            end
          end else if (tick) begin
            cnt_reg <= cnt_inc[CW-1:0];
          end
        end
        SPACE: begin
          if (unit_hit) begin
            cnt_reg   <= '0;
            key_reg   <= 1'b1;
            state_reg <= MARK;
          end else if (tick) begin
            cnt_reg <= cnt_inc[CW-1:0];
          end
        end
        GAP: begin
          if (unit_hit) begin
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (tick) begin
            cnt_reg <= cnt_inc[CW-1:0];
          end
        end
        default: begin
          key_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = ready_reg;
  assign nco_rst   = nco_reg;
  assign key_out   = key_reg;
  assign busy      = busy_reg;
  assign char_done = done_reg;

endmodule

// File: tb/tb_morse_keyer_seq.sv
// Self-checking bench for morse_keyer_seq: vector table, reset corners and random
// descriptors checked against a tick-level reference of the keyed waveform.
`timescale 1ns/1ps
module tb_morse_keyer_seq;

  localparam int PERIOD   = 20;
  localparam int TICK_DIV = 50;
  localparam int DASH     = 3;
  localparam int SYMG     = 1;
  localparam int CHARG    = 3;
  localparam int WORDX    = 4;
  localparam int FWM      = 3;
`ifdef FARNSWORTH_EN
  localparam int GM = FWM;
`else
  localparam int GM = 1;
`endif

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       tick;
  logic       force_tick = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_len = '0;
  logic [4:0] in_code = '0;
  logic       in_space = 1'b0;
  logic       nco_rst;
  logic       key_out;
  logic       busy;
  logic       char_done;

  int total = 0;
  int bad = 0;
  int ph = 0;

  morse_keyer_seq #(
    .MAX_LEN(5), .DASH_UNITS(DASH), .SYM_GAP(SYMG), .CHAR_GAP(CHARG),
    .WORD_EXTRA(WORDX), .FW_MULT(FWM)
  ) dut (
    .clk_in(clk_in), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(in_ready),
    .in_len(in_len), .in_code(in_code), .in_space(in_space), .nco_rst(nco_rst),
    .key_out(key_out), .busy(busy), .char_done(char_done)
  );

  always #(PERIOD/2) clk_in = ~clk_in;

  // Dot-period NCO stand-in: phase restarts whenever nco_rst is low.
  always @(posedge clk_in) begin
    if (!nco_rst) ph <= 0;
    else ph <= (ph == TICK_DIV-1) ? 0 : ph + 1;
  end
  assign tick = (ph == TICK_DIV-1) || force_tick;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected key level at each consumed tick, straight from the Morse timing rules.
  task automatic model(input logic [2:0] len, input logic [4:0] code, input bit space,
                       output logic [63:0] seq, output int n);
    int l;
    seq = '0;
    n = 0;
    if (space) begin
      for (int k = 0; k < WORDX*GM; k++) begin seq[n] = 1'b0; n++; end
    end else begin
      l = (int'(len) > 5) ? 5 : int'(len);
      for (int i = 0; i < l; i++) begin
        for (int k = 0; k < (code[4-i] ? DASH : 1); k++) begin seq[n] = 1'b1; n++; end
        if (i < l-1)
          for (int k = 0; k < SYMG; k++) begin seq[n] = 1'b0; n++; end
      end
      for (int k = 0; k < CHARG*GM; k++) begin seq[n] = 1'b0; n++; end
    end
  endtask

  task automatic junk();
    in_valid = 1'($urandom_range(0, 1));
    in_len   = 3'($urandom);
    in_code  = 5'($urandom);
    in_space = 1'($urandom);
  endtask

  task automatic run_char(input string name, input logic [2:0] len, input logic [4:0] code,
                          input bit space, input int exp_ticks, input int exp_marks);
    logic [63:0] seq;
    logic [63:0] mseq;
    int n, mn, cyc, nco_low;
    bit done;
    cyc = 0;
    while (!in_ready && cyc < 2000) begin @(negedge clk_in); cyc++; end
    check({name, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_len = len; in_code = code; in_space = space;
    @(negedge clk_in);
    check({name, "_accept"}, 64'({in_ready, busy, nco_rst, char_done, key_out}), 64'b01000);
    junk();
    @(negedge clk_in);
    check({name, "_sync"}, 64'(nco_rst), 64'd1);
    n = 0; seq = '0; done = 0; cyc = 0; nco_low = 0;
    while (!done && cyc < 3000) begin
      if (char_done) done = 1;
      else begin
        if (tick && n < 64) begin seq[n] = key_out; n++; end
        if (!nco_rst) nco_low++;
        junk();
        @(negedge clk_in);
        cyc++;
      end
    end
    in_valid = 1'b0;
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_end"}, 64'({in_ready, busy, key_out}), 64'b100);
    check({name, "_nco"}, 64'(nco_low), 64'd0);
    model(len, code, space, mseq, mn);
    check({name, "_nticks"}, 64'(n), 64'(mn));
    check({name, "_wave"}, seq, mseq);
    if (exp_ticks >= 0) check({name, "_tab_ticks"}, 64'(n), 64'(exp_ticks));
    if (exp_marks >= 0) check({name, "_tab_marks"}, 64'($countones(seq)), 64'(exp_marks));
    $display("char %s len=%0d code=%b space=%0d ticks=%0d wave=%b", name, len, code, space, n, seq[31:0]);
  endtask

  typedef struct {
    string      name;
    logic [2:0] len;
    logic [4:0] code;
    bit         space;
    int         ticks;
    int         marks;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       acc;
    logic [2:0] rl;
    logic [4:0] rc;
    bit         rs;
    int         gap;

    vecs[0] = '{"A",    3'd2, 5'b01000, 1'b0, 4 + SYMG + CHARG*GM, 4};
    vecs[1] = '{"E",    3'd1, 5'b00000, 1'b0, 1 + CHARG*GM, 1};
    vecs[2] = '{"WORD", 3'd0, 5'b10101, 1'b1, WORDX*GM, 0};
    vecs[3] = '{"LEN0", 3'd0, 5'b10101, 1'b0, CHARG*GM, 0};
    vecs[4] = '{"LEN7", 3'd7, 5'b11111, 1'b0, 15 + 4*SYMG + CHARG*GM, 15};
    vecs[5] = '{"N",    3'd2, 5'b10000, 1'b0, 4 + SYMG + CHARG*GM, 4};

    // Reset held for three edges, then released.
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_outs", 64'({key_out, nco_rst, in_ready, busy, char_done}), 64'd0);
    rst = 1'b1;
    @(negedge clk_in);
    check("reset_release", 64'({in_ready, nco_rst, key_out, busy}), 64'b1100);

    for (int i = 0; i < 6; i++)
      run_char(vecs[i].name, vecs[i].len, vecs[i].code, vecs[i].space, vecs[i].ticks, vecs[i].marks);

    // Reset during a dash mark, with ticks arriving while reset is held.
    in_valid = 1'b1; in_len = 3'd1; in_code = 5'b10000; in_space = 1'b0;
    @(negedge clk_in);
    in_valid = 1'b0;
    @(negedge clk_in);
    repeat (60) @(negedge clk_in);
    check("dash_mark", 64'({key_out, busy}), 64'b11);
    rst = 1'b0;
    @(negedge clk_in);
    check("midreset_outs", 64'({key_out, in_ready, busy, nco_rst, char_done}), 64'd0);
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      force_tick = i[0];
      @(negedge clk_in);
      acc = acc | key_out | char_done | in_ready | busy;
    end
    force_tick = 1'b0;
    check("midreset_quiet", 64'(acc), 64'd0);
    rst = 1'b1;
    @(negedge clk_in);
    check("midreset_release", 64'({in_ready, nco_rst, key_out, busy, char_done}), 64'b11000);
    run_char("E_after_rst", 3'd1, 5'b00000, 1'b0, 1 + CHARG*GM, 1);

    // Random descriptors with random idle spacing (including back-to-back).
    for (int i = 0; i < 30; i++) begin
      rl  = 3'($urandom_range(0, 7));
      rc  = 5'($urandom);
      rs  = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
      acc = 1'b0;
      for (int k = 0; k < gap; k++) begin
        @(negedge clk_in);
        acc = acc | char_done | key_out;
      end
      if (gap > 0) check("idle_quiet", 64'(acc), 64'd0);
      run_char($sformatf("rnd%0d", i), rl, rc, rs, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
